// File: rtl/riscv_uart_rx_if.sv
// ---------------------------------------------------------------------------
// riscv_uart_rx_if
// Byte delivery interface between the UART receive deserializer and the
// riscv_uart register block.
//
// Signals:
//   rx_data     receiver -> consumer  received byte held in the output register
//   rx_valid    receiver -> consumer  rx_data holds an unconsumed byte
//   rx_ready    consumer -> receiver  byte accepted when rx_valid && rx_ready
//   frame_err   receiver -> consumer  sticky: a stop bit was sampled low
//   overrun     receiver -> consumer  sticky: byte completed while rx_valid high
//   clr_status  consumer -> receiver  one-cycle pulse clearing the sticky flags
//   busy        receiver -> consumer  receive FSM is not idle
//   parity_err  receiver -> consumer  sticky parity mismatch (only when the
//                                     RISCV_UART_RX_PARITY_EN macro is defined)
//
// Modports: master = receiver side, slave = consumer side.
// ---------------------------------------------------------------------------
interface riscv_uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       clr_status;
    logic       busy;
`ifdef RISCV_UART_RX_PARITY_EN
    logic       parity_err;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, busy, parity_err,
        input  rx_ready, clr_status
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, busy, parity_err,
        output rx_ready, clr_status
    );
`else
    modport master (
        output rx_data, rx_valid, frame_err, overrun, busy,
        input  rx_ready, clr_status
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, busy,
        output rx_ready, clr_status
    );
`endif
endinterface

// File: rtl/riscv_uart_rx.sv
// ---------------------------------------------------------------------------
// riscv_uart_rx
// Receive-side deserializer for the riscv_uart. Synchronizes the asynchronous
// rxd line, detects start bits, samples each bit at mid-bit and assembles
// 8N1 frames (8E1 style frame with a checked parity bit when the optional
// feature is built in). Completed bytes land in a one-entry holding register
// handed to the register block through a valid/ready handshake, together
// with sticky framing / overrun (and parity) status.
//
// Optional feature macro: RISCV_UART_RX_PARITY_EN
//   defined   -> a parity bit follows the data bits; a mismatch against even
//                parity of the data sets the sticky parity_err flag.
//   undefined -> plain 8N1, no parity state, no parity_err signal.
//
// Parameters:
//   SCALER       clock cycles per serial bit (>= 4)
//   SYNC_STAGES  flip-flops in the rxd synchronizer (>= 2)
//
// Ports:
//   clk    system clock
//   rst    asynchronous active-high reset
//   i_rxd  serial input, idle high, asynchronous to clk
//   bus    riscv_uart_rx_if.master: rx_data, rx_valid, rx_ready, frame_err,
//          overrun, clr_status, busy (and parity_err when enabled)
// ---------------------------------------------------------------------------
module riscv_uart_rx #(
    parameter int SCALER      = 2604,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_rxd,
    riscv_uart_rx_if.master        bus
);

    localparam int CW = $clog2(SCALER);
    localparam logic [CW-1:0] HALF_LOAD = CW'(SCALER / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(SCALER - 1);

    typedef enum logic [2:0] {
`ifdef RISCV_UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    // Synchronizer and receive datapath
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;
    state_t                 r_state;
    state_t                 w_stateNext;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cntNext;
    logic [2:0]             r_bitIdx;
    logic [2:0]             w_bitIdxNext;
    logic [7:0]             r_shift;
    logic [7:0]             w_shiftNext;
    logic                   w_stopSample;
    logic                   w_stopBad;
    logic                   r_deliver;
    logic                   r_frameBad;

    // Output holding stage and sticky status
    logic [7:0]             r_rxData;
    logic                   r_rxValid;
    logic                   r_frameErr;
    logic                   r_overrun;
    logic                   w_overrunSet;
    logic                   w_frameSet;

`ifdef RISCV_UART_RX_PARITY_EN
    logic                   w_paritySample;
    logic                   w_parityMismatch;
    logic                   r_parityBad;
    logic                   r_parityErr;
    logic                   w_parityErrSet;
`endif

    // Preset to all-ones so reset looks like an idle line and never fakes a
    // start bit on the first cycles after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rxd};
        end
    end

    assign w_rxs = r_sync[SYNC_STAGES-1];

    // State register and receive datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bitIdx   <= 3'd0;
            r_shift    <= 8'h00;
            r_deliver  <= 1'b0;
            r_frameBad <= 1'b0;
`ifdef RISCV_UART_RX_PARITY_EN
            r_parityBad <= 1'b0;
`endif
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_bitIdx  <= w_bitIdxNext;
            r_shift   <= w_shiftNext;
            r_deliver <= w_stopSample;
            if (w_stopSample) begin
                r_frameBad <= w_stopBad;
            end
`ifdef RISCV_UART_RX_PARITY_EN
            if (w_paritySample) begin
                r_parityBad <= w_parityMismatch;
            end
`endif
        end
    end

    // Next-state logic. The baud counter free-runs down to zero inside a
    // state and is reloaded on every state change, so each sample point sits
    // a whole bit period after the previous one, starting from mid start bit.
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = (r_cnt != '0) ? (r_cnt - 1'b1) : r_cnt;
        w_bitIdxNext = r_bitIdx;
        w_shiftNext  = r_shift;
        w_stopSample = 1'b0;
        w_stopBad    = 1'b0;
`ifdef RISCV_UART_RX_PARITY_EN
        w_paritySample   = 1'b0;
        w_parityMismatch = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_cntNext = '0;
                if (!w_rxs) begin
                    w_stateNext = S_START;
                    w_cntNext   = HALF_LOAD;
                end
            end
            S_START: begin
                if (r_cnt == '0) begin
                    if (w_rxs) begin
                        // Line went back high before mid start bit: glitch.
                        w_stateNext = S_IDLE;
                        w_cntNext   = '0;
                    end else begin
                        w_stateNext  = S_DATA;
                        w_bitIdxNext = 3'd0;
                        w_cntNext    = FULL_LOAD;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == '0) begin
                    w_shiftNext = {w_rxs, r_shift[7:1]};
                    w_cntNext   = FULL_LOAD;
                    if (r_bitIdx == 3'd7) begin
`ifdef RISCV_UART_RX_PARITY_EN
                        w_stateNext = S_PARITY;
`else
                        w_stateNext = S_STOP;
`endif
                    end else begin
                        w_bitIdxNext = 3'(r_bitIdx + 3'd1);
                    end
                end
            end
`ifdef RISCV_UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == '0) begin
                    w_paritySample   = 1'b1;
                    w_parityMismatch = (w_rxs != (^r_shift));
                    w_stateNext      = S_STOP;
                    w_cntNext        = FULL_LOAD;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == '0) begin
                    w_stopSample = 1'b1;
                    w_stopBad    = ~w_rxs;
                    w_stateNext  = S_WAIT_IDLE;
                    w_cntNext    = '0;
                end
            end
            S_WAIT_IDLE: begin
                // Hold off while the line is low so a break is one frame only.
                w_cntNext = '0;
                if (w_rxs) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    // An overrun is only flagged when the held byte is not being consumed in
    // the same cycle the new byte arrives; a simultaneous consume is clean.
    assign w_overrunSet = r_deliver && r_rxValid && !bus.rx_ready;
    assign w_frameSet   = r_deliver && r_frameBad;
`ifdef RISCV_UART_RX_PARITY_EN
    assign w_parityErrSet = r_deliver && r_parityBad;
`endif

    // Holding register and sticky flags. Set events take priority over
    // clr_status; the newest byte always overwrites the held one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxData   <= 8'h00;
            r_rxValid  <= 1'b0;
            r_frameErr <= 1'b0;
            r_overrun  <= 1'b0;
`ifdef RISCV_UART_RX_PARITY_EN
            r_parityErr <= 1'b0;
`endif
        end else begin
            if (r_deliver) begin
                r_rxData  <= r_shift;
                r_rxValid <= 1'b1;
            end else if (r_rxValid && bus.rx_ready) begin
                r_rxValid <= 1'b0;
            end

            if (w_frameSet) begin
                r_frameErr <= 1'b1;
            end else if (bus.clr_status) begin
                r_frameErr <= 1'b0;
            end

            if (w_overrunSet) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_status) begin
                r_overrun <= 1'b0;
            end

`ifdef RISCV_UART_RX_PARITY_EN
            if (w_parityErrSet) begin
                r_parityErr <= 1'b1;
            end else if (bus.clr_status) begin
                r_parityErr <= 1'b0;
            end
`endif
        end
    end

    assign bus.rx_data   = r_rxData;
    assign bus.rx_valid  = r_rxValid;
    assign bus.frame_err = r_frameErr;
    assign bus.overrun   = r_overrun;
    assign bus.busy      = (r_state != S_IDLE);
`ifdef RISCV_UART_RX_PARITY_EN
    assign bus.parity_err = r_parityErr;
`endif

endmodule

// File: tb/tb_riscv_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_riscv_uart_rx
// Directed testbench for riscv_uart_rx with SCALER=16, SYNC_STAGES=2.
// Frames are driven bit by bit on rxd; expected values are hand-computed.
// Build with RISCV_UART_RX_PARITY_EN defined to also exercise parity.
// ---------------------------------------------------------------------------
module tb_riscv_uart_rx;

    localparam int SCALER      = 16;
    localparam int SYNC_STAGES = 2;

    logic clk = 1'b0;
    logic rst;
    logic rxd;

    int checkCount = 0;
    int errorCount = 0;

    riscv_uart_rx_if bus();

    riscv_uart_rx #(
        .SCALER      (SCALER),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .i_rxd (rxd),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Single comparison point: every check is counted, mismatches reported.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Hold one serial bit on rxd for a full bit period.
    task automatic sendBit(input logic b);
        rxd = b;
        repeat (SCALER) @(negedge clk);
    endtask

    task automatic sendDataBits(input logic [7:0] data);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) begin
            sendBit(data[i]);
        end
    endtask

    // One complete frame; rxd is left at the stop-bit level afterwards.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        sendDataBits(data);
`ifdef RISCV_UART_RX_PARITY_EN
        sendBit(^data);
`endif
        sendBit(stopBit);
    endtask

`ifdef RISCV_UART_RX_PARITY_EN
    task automatic applyParityFrame(input logic [7:0] data, input logic parityBit);
        sendDataBits(data);
        sendBit(parityBit);
        sendBit(1'b1);
    endtask
`endif

    task automatic pulseReady();
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    task automatic pulseClear();
        bus.clr_status = 1'b1;
        @(negedge clk);
        bus.clr_status = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic sawBusy;
        logic sawValid;

        rxd            = 1'b1;
        rst            = 1'b1;
        bus.rx_ready   = 1'b0;
        bus.clr_status = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("reset rx_valid", 32'(bus.rx_valid), 32'd0);
        checkOutput("reset rx_data", 32'(bus.rx_data), 32'h00);
        checkOutput("reset frame_err", 32'(bus.frame_err), 32'd0);
        checkOutput("reset overrun", 32'(bus.overrun), 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);

        // Single byte with no consumer, then a one-cycle accept.
        $display("[TB] byte 0xA5");
        applyStimulus(8'hA5, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("a5 rx_valid", 32'(bus.rx_valid), 32'd1);
        checkOutput("a5 rx_data", 32'(bus.rx_data), 32'hA5);
        checkOutput("a5 frame_err", 32'(bus.frame_err), 32'd0);
        checkOutput("a5 overrun", 32'(bus.overrun), 32'd0);
        checkOutput("a5 busy", 32'(bus.busy), 32'd0);
`ifdef RISCV_UART_RX_PARITY_EN
        checkOutput("a5 parity_err", 32'(bus.parity_err), 32'd0);
`endif
        repeat (10) @(negedge clk);
        checkOutput("a5 held valid", 32'(bus.rx_valid), 32'd1);
        checkOutput("a5 held data", 32'(bus.rx_data), 32'hA5);
        pulseReady();
        checkOutput("a5 consumed", 32'(bus.rx_valid), 32'd0);

        // Two back-to-back bytes without consumption: newest wins.
        $display("[TB] overrun 0x3C then 0xC3");
        applyStimulus(8'h3C, 1'b1);
        checkOutput("3c rx_data", 32'(bus.rx_data), 32'h3C);
        checkOutput("3c overrun", 32'(bus.overrun), 32'd0);
        applyStimulus(8'hC3, 1'b1);
        checkOutput("c3 rx_valid", 32'(bus.rx_valid), 32'd1);
        checkOutput("c3 rx_data", 32'(bus.rx_data), 32'hC3);
        checkOutput("c3 overrun", 32'(bus.overrun), 32'd1);
        pulseClear();
        checkOutput("overrun cleared", 32'(bus.overrun), 32'd0);
        pulseReady();
        checkOutput("c3 consumed", 32'(bus.rx_valid), 32'd0);

        // Low stop bit, line held low as a break.
        $display("[TB] framing error 0x55");
        applyStimulus(8'h55, 1'b0);
        checkOutput("55 rx_valid", 32'(bus.rx_valid), 32'd1);
        checkOutput("55 rx_data", 32'(bus.rx_data), 32'h55);
        checkOutput("55 frame_err", 32'(bus.frame_err), 32'd1);
        checkOutput("55 busy in break", 32'(bus.busy), 32'd1);
        repeat (40) @(negedge clk);
        checkOutput("break still busy", 32'(bus.busy), 32'd1);
        checkOutput("break no overrun", 32'(bus.overrun), 32'd0);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("break released busy", 32'(bus.busy), 32'd0);
        pulseClear();
        checkOutput("frame_err cleared", 32'(bus.frame_err), 32'd0);
        pulseReady();
        checkOutput("55 consumed", 32'(bus.rx_valid), 32'd0);

        // Short low glitch is rejected at the start-bit sample.
        $display("[TB] glitch");
        sawBusy  = 1'b0;
        sawValid = 1'b0;
        rxd = 1'b0;
        repeat (4) begin
            @(negedge clk);
            sawBusy = sawBusy | bus.busy;
        end
        rxd = 1'b1;
        repeat (40) begin
            @(negedge clk);
            sawBusy  = sawBusy | bus.busy;
            sawValid = sawValid | bus.rx_valid;
        end
        checkOutput("glitch seen busy", 32'(sawBusy), 32'd1);
        checkOutput("glitch no valid", 32'(sawValid), 32'd0);
        checkOutput("glitch busy idle", 32'(bus.busy), 32'd0);
        checkOutput("glitch frame_err", 32'(bus.frame_err), 32'd0);
        checkOutput("glitch overrun", 32'(bus.overrun), 32'd0);

        // Reset in the middle of data bit 4 of 0xFF.
        $display("[TB] reset mid-frame");
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) begin
            sendBit(1'b1);
        end
        rxd = 1'b1;
        repeat (SCALER / 2) @(negedge clk);
        checkOutput("midframe busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("async reset busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (SCALER * 6) @(negedge clk);
        checkOutput("no partial byte", 32'(bus.rx_valid), 32'd0);
        applyStimulus(8'h12, 1'b1);
        checkOutput("12 rx_valid", 32'(bus.rx_valid), 32'd1);
        checkOutput("12 rx_data", 32'(bus.rx_data), 32'h12);
        checkOutput("12 frame_err", 32'(bus.frame_err), 32'd0);
        checkOutput("12 overrun", 32'(bus.overrun), 32'd0);
        pulseReady();

`ifdef RISCV_UART_RX_PARITY_EN
        // 0x07 has three ones, so even parity requires a 1.
        $display("[TB] parity");
        applyParityFrame(8'h07, 1'b0);
        checkOutput("par0 rx_data", 32'(bus.rx_data), 32'h07);
        checkOutput("par0 parity_err", 32'(bus.parity_err), 32'd1);
        checkOutput("par0 frame_err", 32'(bus.frame_err), 32'd0);
        pulseReady();
        pulseClear();
        checkOutput("parity cleared", 32'(bus.parity_err), 32'd0);
        applyParityFrame(8'h07, 1'b1);
        checkOutput("par1 rx_data", 32'(bus.rx_data), 32'h07);
        checkOutput("par1 parity_err", 32'(bus.parity_err), 32'd0);
        pulseReady();
`endif

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/riscv_uart_rx.md
Name: riscv_uart_rx

Overview:
Receive-side deserializer that sits between the board rxd pin and the riscv_uart register block. It synchronizes the asynchronous serial line, detects start bits, samples each bit at mid-bit, and assembles 8N1 frames. Each completed byte is presented to the register block through a one-entry valid/ready holding stage, with framing and overrun status.

Parameters:
SCALER, 2604, clock cycles per serial bit (2604 gives 19200 baud at 50 MHz); must be >= 4.
SYNC_STAGES, 2, number of flip-flops in the rxd synchronizer; must be >= 2.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rxd  input  1  serial input line, idle high, asynchronous to clk
rx_data  output  8  received byte held in the output register
rx_valid  output  1  rx_data holds an unconsumed byte
rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready
frame_err  output  1  sticky: a stop bit was sampled low
overrun  output  1  sticky: a byte completed while rx_valid was still high
clr_status  input  1  single-cycle pulse that clears frame_err, overrun and parity_err
busy  output  1  FSM is not in IDLE

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, and the synchronizer flops are preset to 1 (idle line).
- rxd passes through SYNC_STAGES flops. rxs is the synchronized bit. All decisions use rxs only.
- Baud counter width is $clog2(SCALER). It reloads on every state entry.
- FSM:
  - IDLE: when rxs==0, go to START and load counter with SCALER/2-1. busy=0 only in IDLE.
  - START: when the counter reaches 0, sample rxs. If rxs==1, treat it as a glitch and return to IDLE with no status change. If rxs==0, go to DATA with bit index 0 and counter SCALER-1.
  - DATA: at each counter expiry, shift rxs into the shift register LSB-first and increment the index. After bit 7 is sampled, go to PARITY if the optional feature is enabled, otherwise go to STOP. Counter reloads SCALER-1.
  - STOP: at counter expiry, sample rxs.
    - If rxs==1, the frame is good.
    - If rxs==0, set frame_err and still deliver the byte.
    - Then go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs==1, then go to IDLE. This prevents a break condition from retriggering frames.
- Delivery happens on the cycle after the stop-bit sample:
  - rx_data is loaded and rx_valid is set to 1.
  - If rx_valid was already 1 and was not consumed in that same cycle, set overrun and overwrite rx_data with the new byte (newest wins).
- Handshake:
  - rx_valid stays high until a cycle with rx_ready=1, then deasserts on the next edge.
  - rx_data is stable while rx_valid is high, unless an overrun overwrite occurs.
  - If a consume and a new delivery fall in the same cycle, rx_valid stays 1, the new byte is loaded and overrun is not set.
- clr_status clears the sticky flags on the next edge. If a set event occurs in the same cycle, the set wins.
- A rst assertion mid-frame aborts the frame immediately. No partial byte is delivered.
- Latency: rx_valid rises SYNC_STAGES + SCALER/2 + 9*SCALER + 1 cycles (approximately) after the rxd falling edge. With no parity, SCALER=16 and SYNC_STAGES=2 this is 2+8+144+1 = 155 cycles, with ±1 cycle of edge-sampling uncertainty.

Optional Feature:
Macro: RISCV_UART_RX_PARITY_EN.
- Defined:
  - The PARITY state is inserted after DATA. It samples one bit at counter expiry.
  - A mismatch against even parity of the 8 data bits sets the sticky output parity_err, which is cleared by clr_status.
  - The byte is still delivered.
  - The parity_err port exists.
  - Latency grows by SCALER.
- Undefined:
  - The PARITY state and the parity_err port do not exist.
  - The frame is 8N1.

Test Plan:
- SCALER=16, reset then send 0xA5 (8N1) with rx_ready=0 -> rx_valid=1, rx_data=0xA5, frame_err=0, overrun=0; pulsing rx_ready=1 for one cycle -> rx_valid=0 on the next edge.
- Send 0x3C then 0xC3 back-to-back with rx_ready held 0 -> rx_data=0xC3, overrun=1; clr_status pulse -> overrun=0.
- Send 0x55 with the stop bit driven 0, then return rxd high -> rx_data=0x55, frame_err=1, busy returns 0 only after rxd is high.
- Drive a 4-cycle low glitch on rxd, below the SCALER/2 width -> no rx_valid, busy returns to 0, no status bits set.
- Assert rst midway through bit 4 of 0xFF, release, then send 0x12 -> only 0x12 is delivered, with no errors.
- With RISCV_UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> rx_data=0x07, parity_err=1; send 0x07 with parity 1 -> parity_err stays 0 after clr_status.
